// File: rtl/rv32_lsu.sv
// rv32_lsu: RV32 load/store unit, one outstanding access on the core data-memory port.
// LR/SC reservation support is compiled in when LSU_LRSC_EN is defined.
module rv32_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic [1:0]  rsp_cause,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_valid
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_LR    = 2'b10;
  localparam logic [1:0] OP_SC    = 2'b11;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_ILL   = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_LD_MISAL = 2'b01;
  localparam logic [1:0] CAUSE_ST_MISAL = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  logic [1:0]  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [4:0]  rd_q, rd_d;

  logic        req_ready_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_data_d;
  logic [4:0]  rsp_rd_d;
  logic        rsp_err_d;
  logic [1:0]  rsp_cause_d;
  logic [31:0] dmem_addr_d;
  logic [31:0] dmem_wdata_d;
  logic [3:0]  dmem_be_d;
  logic        dmem_req_d;
  logic        dmem_we_d;

  logic        req_fire;
  logic        req_illegal;
  logic        req_misal;
  logic        req_sc_fail;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

`ifdef LSU_LRSC_EN
  logic        resv_valid_q, resv_valid_d;
  logic [29:0] resv_addr_q, resv_addr_d;
`endif

  // Request classification; illegal encodings outrank misalignment.
  always_comb begin
    req_fire    = req_valid && req_ready;
    req_illegal = (req_size == SZ_ILL) || (req_op[1] && (req_size != SZ_WORD));
`ifndef LSU_LRSC_EN
    req_illegal = req_illegal || req_op[1];
`endif
    req_misal   = ((req_size == SZ_HALF) && req_addr[0]) ||
                  ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`ifdef LSU_LRSC_EN
    req_sc_fail = (req_op == OP_SC) &&
                  !(resv_valid_q && (resv_addr_q == req_addr[31:2]));
`else
    req_sc_fail = 1'b0;
`endif
  end

  // Byte enables and lane-replicated store data for the accepted request.
  always_comb begin
    case (req_size)
      SZ_BYTE: begin
        be_c    = 4'b0001 << req_addr[1:0];
        wdata_c = {4{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be_c    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{req_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = req_wdata;
      end
    endcase
  end

  // Align returned word to the addressed lane, then extend.
  always_comb begin
    ld_shift = dmem_rdata >> {dmem_addr[1:0], 3'b000};
    case (size_q)
      SZ_BYTE: ld_data = uns_q ? {24'd0, ld_shift[7:0]}
                               : {{24{ld_shift[7]}}, ld_shift[7:0]};
      SZ_HALF: ld_data = uns_q ? {16'd0, ld_shift[15:0]}
                               : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  // Next state and next values of every registered output.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    size_d       = size_q;
    uns_d        = uns_q;
    rd_d         = rd_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data;
    rsp_rd_d     = rsp_rd;
    rsp_err_d    = rsp_err;
    rsp_cause_d  = rsp_cause;
    dmem_addr_d  = dmem_addr;
    dmem_wdata_d = dmem_wdata;
    dmem_be_d    = dmem_be;
    dmem_req_d   = 1'b0;
    dmem_we_d    = 1'b0;
`ifdef LSU_LRSC_EN
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          op_d   = req_op;
          size_d = req_size;
          uns_d  = req_unsigned;
          rd_d   = req_rd;
          if (req_illegal || req_misal || req_sc_fail) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rd_d    = req_rd;
            rsp_err_d   = req_illegal || req_misal;
            rsp_data_d  = (req_illegal || req_misal) ? 32'd0 : 32'd1;
            if (req_illegal)    rsp_cause_d = CAUSE_ILLEGAL;
            else if (req_misal) rsp_cause_d = req_op[0] ? CAUSE_ST_MISAL : CAUSE_LD_MISAL;
            else                rsp_cause_d = CAUSE_NONE;
          end else begin
            state_d      = ST_ISSUE;
            dmem_req_d   = 1'b1;
            dmem_we_d    = req_op[0];
            dmem_addr_d  = req_addr;
            dmem_be_d    = be_c;
            dmem_wdata_d = wdata_c;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (dmem_valid) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rd_d    = rd_q;
          rsp_err_d   = 1'b0;
          rsp_cause_d = CAUSE_NONE;
          rsp_data_d  = op_q[0] ? 32'd0 : ld_data;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef LSU_LRSC_EN
    // Any SC drops the reservation; a successful LR or overlapping store updates it.
    if (req_fire && (state_q == ST_IDLE)) begin
      if (req_op == OP_SC) begin
        resv_valid_d = 1'b0;
      end else if (!req_illegal && !req_misal) begin
        if (req_op == OP_LR) begin
          resv_valid_d = 1'b1;
          resv_addr_d  = req_addr[31:2];
        end else if ((req_op == OP_STORE) && (req_addr[31:2] == resv_addr_q)) begin
          resv_valid_d = 1'b0;
        end
      end
    end
`endif

    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_LOAD;
      size_q     <= SZ_BYTE;
      uns_q      <= 1'b0;
      rd_q       <= 5'd0;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_rd     <= 5'd0;
      rsp_err    <= 1'b0;
      rsp_cause  <= CAUSE_NONE;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
`ifdef LSU_LRSC_EN
      resv_valid_q <= 1'b0;
      resv_addr_q  <= 30'd0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      rd_q       <= rd_d;
      req_ready  <= req_ready_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      rsp_rd     <= rsp_rd_d;
      rsp_err    <= rsp_err_d;
      rsp_cause  <= rsp_cause_d;
      dmem_addr  <= dmem_addr_d;
      dmem_wdata <= dmem_wdata_d;
      dmem_be    <= dmem_be_d;
      dmem_req   <= dmem_req_d;
      dmem_we    <= dmem_we_d;
`ifdef LSU_LRSC_EN
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// Scoreboard bench for rv32_lsu: directed requests push expected memory/response records,
// independent monitors pop and compare them whenever the DUT presents dmem_req or rsp_valid.
module tb_rv32_lsu;

  localparam logic [1:0] OP_LOAD = 2'b00, OP_STORE = 2'b01, OP_LR = 2'b10, OP_SC = 2'b11;
  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic [1:0]  rsp_cause;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_rdata = 32'd0;
  logic        dmem_valid = 1'b0;

  rv32_lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .rsp_cause(rsp_cause),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
    logic [1:0]  cause;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    int          cyc;
  } mem_t;

  rsp_t rq[$];
  mem_t mq[$];
  rsp_t re;
  mem_t me;
  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endfunction

  // Memory model: answers after mem_delay extra cycles; poke forces a stray dmem_valid.
  logic [31:0] mem_word = 32'd0;
  int          mem_delay = 0;
  bit          mem_auto = 1'b1;
  bit          poke = 1'b0;
  int          pend = 0;

  always @(posedge clk) begin
    dmem_valid <= 1'b0;
    if (poke) begin
      dmem_valid <= 1'b1;
      dmem_rdata <= mem_word;
    end else if (pend == 1) begin
      dmem_valid <= 1'b1;
      dmem_rdata <= mem_word;
      pend <= 0;
    end else if (pend > 1) begin
      pend <= pend - 1;
    end
    if (dmem_req && mem_auto) begin
      if (mem_delay == 0) begin
        dmem_valid <= 1'b1;
        dmem_rdata <= mem_word;
      end else begin
        pend <= mem_delay;
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_unexpected: actual rsp_valid=1 rd=%0d data=%h required no response",
                 rsp_rd, rsp_data);
      end else begin
        re = rq.pop_front();
        chk("rsp_cycle", 32'(cyc), 32'(re.cyc));
        chk("rsp_data", rsp_data, re.data);
        chk("rsp_rd", 32'(rsp_rd), 32'(re.rd));
        chk("rsp_err", 32'(rsp_err), 32'(re.err));
        chk("rsp_cause", 32'(rsp_cause), 32'(re.cause));
      end
    end
  end

  // Memory-port monitor.
  always @(negedge clk) begin
    if (dmem_req) begin
      if (mq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dmem_unexpected: actual dmem_req=1 addr=%h required no access", dmem_addr);
      end else begin
        me = mq.pop_front();
        chk("dmem_cycle", 32'(cyc), 32'(me.cyc));
        chk("dmem_addr", dmem_addr, me.addr);
        chk("dmem_be", 32'(dmem_be), 32'(me.be));
        chk("dmem_we", 32'(dmem_we), 32'(me.we));
        if (me.we) chk("dmem_wdata", dmem_wdata, me.wdata);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input logic [31:0] word,
                       input bit mem_exp, input logic [3:0] be, input logic [31:0] mwdata,
                       input logic we,
                       input bit rsp_exp, input logic [31:0] data, input logic err,
                       input logic [1:0] cause, input int lat);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: actual req_ready=0 required 1 within 100 cycles");
    end
    mem_word     = word;
    req_valid    = 1'b1;
    req_op       = op;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_rd       = rd;
    if (mem_exp) mq.push_back('{addr: addr, wdata: mwdata, be: be, we: we, cyc: cyc + 1});
    if (rsp_exp) rq.push_back('{data: data, rd: rd, err: err, cause: cause, cyc: cyc + lat});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic ld(input logic [1:0] size, input logic uns, input logic [31:0] addr,
                    input logic [31:0] word, input logic [3:0] be, input logic [31:0] data,
                    input logic [4:0] rd);
    issue(OP_LOAD, size, uns, addr, 32'h0, rd, word, 1'b1, be, 32'h0, 1'b0,
          1'b1, data, 1'b0, 2'b00, 3);
  endtask

  task automatic st(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [3:0] be, input logic [31:0] mwdata, input logic [4:0] rd);
    issue(OP_STORE, size, 1'b0, addr, wdata, rd, 32'h0, 1'b1, be, mwdata, 1'b1,
          1'b1, 32'h0, 1'b0, 2'b00, 3);
  endtask

  task automatic bad(input logic [1:0] op, input logic [1:0] size, input logic [31:0] addr,
                     input logic [1:0] cause, input logic [4:0] rd);
    issue(op, size, 1'b0, addr, 32'h0, rd, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0,
          1'b1, 32'h0, 1'b1, cause, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((rq.size() != 0 || mq.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || mq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: actual %0d rsp / %0d dmem pending required 0",
               rq.size(), mq.size());
      rq.delete();
      mq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_reset_values();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_we", 32'(dmem_we), 32'd0);
    chk("rst_dmem_be", 32'(dmem_be), 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_dmem_wdata", dmem_wdata, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_cause", 32'(rsp_cause), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_values();
    rst = 1'b0;

    // Loads: lane selection and extension.
    ld(SZ_B, 1'b0, 32'h8000_0003, 32'h80FF_1234, 4'b1000, 32'hFFFF_FF80, 5'd1);
    ld(SZ_B, 1'b1, 32'h8000_0003, 32'h80FF_1234, 4'b1000, 32'h0000_0080, 5'd2);
    ld(SZ_H, 1'b0, 32'h8000_0002, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF, 5'd3);
    ld(SZ_H, 1'b1, 32'h8000_0000, 32'h80FF_1234, 4'b0011, 32'h0000_1234, 5'd4);
    ld(SZ_B, 1'b0, 32'h8000_0001, 32'h80FF_1234, 4'b0010, 32'h0000_0012, 5'd5);
    ld(SZ_W, 1'b0, 32'h8000_0004, 32'h80FF_1234, 4'b1111, 32'h80FF_1234, 5'd6);

    // Stores: replication and byte enables.
    st(SZ_B, 32'h8000_0001, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB, 5'd7);
    st(SZ_H, 32'h8000_1002, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD, 5'd8);
    st(SZ_W, 32'h8000_0008, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 5'd9);

    // Misaligned and illegal requests.
    bad(OP_LOAD,  SZ_W, 32'h8000_0006, 2'b01, 5'd10);
    bad(OP_STORE, SZ_W, 32'h8000_0002, 2'b10, 5'd11);
    bad(OP_STORE, SZ_H, 32'h8000_0001, 2'b10, 5'd12);
    bad(OP_LOAD,  SZ_H, 32'h8000_0003, 2'b01, 5'd13);
    bad(OP_LOAD,  SZ_X, 32'h8000_0001, 2'b11, 5'd14);
    bad(OP_LR,    SZ_B, 32'h8000_0100, 2'b11, 5'd15);

    // Slow memory: five extra wait cycles.
    drain();
    mem_delay = 5;
    issue(OP_LOAD, SZ_W, 1'b0, 32'h8000_0010, 32'h0, 5'd16, 32'hCAFE_F00D,
          1'b1, 4'b1111, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 2'b00, 8);
    repeat (4) @(negedge clk);
    chk("wait_req_ready", 32'(req_ready), 32'd0);
    drain();
    mem_delay = 0;

`ifdef LSU_LRSC_EN
    issue(OP_LR, SZ_W, 1'b0, 32'h8000_0100, 32'h0, 5'd17, 32'h1122_3344,
          1'b1, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h1122_3344, 1'b0, 2'b00, 3);
    issue(OP_SC, SZ_W, 1'b0, 32'h8000_0100, 32'h0000_0055, 5'd18, 32'h0,
          1'b1, 4'b1111, 32'h0000_0055, 1'b1, 1'b1, 32'h0, 1'b0, 2'b00, 3);
    issue(OP_SC, SZ_W, 1'b0, 32'h8000_0100, 32'h0000_0066, 5'd19, 32'h0,
          1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0, 2'b00, 1);
    issue(OP_LR, SZ_W, 1'b0, 32'h8000_0200, 32'h0, 5'd20, 32'h0000_0777,
          1'b1, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h0000_0777, 1'b0, 2'b00, 3);
    st(SZ_W, 32'h8000_0204, 32'h0000_0001, 4'b1111, 32'h0000_0001, 5'd21);
    issue(OP_SC, SZ_W, 1'b0, 32'h8000_0200, 32'h0000_0099, 5'd22, 32'h0,
          1'b1, 4'b1111, 32'h0000_0099, 1'b1, 1'b1, 32'h0, 1'b0, 2'b00, 3);
    issue(OP_LR, SZ_W, 1'b0, 32'h8000_0200, 32'h0, 5'd23, 32'h0000_0888,
          1'b1, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h0000_0888, 1'b0, 2'b00, 3);
    st(SZ_B, 32'h8000_0203, 32'h0000_0042, 4'b1000, 32'h4242_4242, 5'd24);
    issue(OP_SC, SZ_W, 1'b0, 32'h8000_0200, 32'h0000_00AA, 5'd25, 32'h0,
          1'b0, 4'h0, 32'h0, 1'b0, 1'b1, 32'h1, 1'b0, 2'b00, 1);
`else
    bad(OP_LR, SZ_W, 32'h8000_0100, 2'b11, 5'd17);
    bad(OP_SC, SZ_W, 32'h8000_0100, 2'b11, 5'd18);
`endif

    // Reset while waiting on memory, then a late dmem_valid.
    drain();
    mem_auto = 1'b0;
    issue(OP_LOAD, SZ_W, 1'b0, 32'h8000_0020, 32'h0, 5'd26, 32'h5555_AAAA,
          1'b1, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 2'b00, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_values();
    rst  = 1'b0;
    poke = 1'b1;
    @(negedge clk);
    poke = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    // Stray dmem_valid while idle must not produce a response.
    poke = 1'b1;
    @(negedge clk);
    poke = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_stray_rsp", 32'(rsp_valid), 32'd0);
    mem_auto = 1'b1;

    ld(SZ_H, 1'b0, 32'h8000_0030, 32'h0000_7FFF, 4'b0011, 32'h0000_7FFF, 5'd27);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
